// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I-subset datapath, with a retired-instruction counter.
// Define BNE_EN to let BRANCH take bne (funct3=001) when ZERO is clear.
module multicycle_controller #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instruction,
  input  logic               ZERO,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [2:0]         OpCode,
  output logic [2:0]         ImmSrc,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_retired
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
    StExecI, StAluWb, StBranch, StJal, StJalr, StLink, StLui
  } state_e;

  state_e state_q, state_d;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       illegal_op;
  logic       branch_taken;
  logic [2:0] alu_dec;

  assign op       = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7b5 = instruction[30];

  always_comb begin
    illegal_op = 1'b0;
    unique case (op)
      OpLoad, OpStore, OpRtype, OpItype, OpBranch, OpJal, OpJalr, OpLui: illegal_op = 1'b0;
      default: illegal_op = 1'b1;
    endcase
  end

  always_comb begin
`ifdef BNE_EN
    branch_taken = ((funct3 == 3'b000) & ZERO) | ((funct3 == 3'b001) & ~ZERO);
`else
    branch_taken = (funct3 == 3'b000) & ZERO;
`endif
  end

  // Only R-type turns funct3=000 into SUB; addi ignores bit 30 (it is immediate data).
  always_comb begin
    unique case (funct3)
      3'b000:  alu_dec = (state_q == StExecR && funct7b5) ? AluSub : AluAdd;
      3'b111:  alu_dec = AluAnd;
      3'b110:  alu_dec = AluOr;
      3'b010:  alu_dec = AluSlt;
      default: alu_dec = AluAdd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:         state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:        state_d = StMemWb;
      StExecR, StExecI: state_d = StAluWb;
      StJal, StJalr:    state_d = StLink;
      StMemWb, StMemWrite, StAluWb, StBranch, StLink, StLui: state_d = StFetch;
      default:          state_d = StFetch;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    OpCode     = AluAdd;
    instr_done = 1'b0;

    unique case (op)
      OpStore:  ImmSrc = 3'b001;
      OpBranch: ImmSrc = 3'b010;
      OpJal:    ImmSrc = 3'b011;
      OpLui:    ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase

    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      StDecode: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        instr_done = illegal_op;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        OpCode  = alu_dec;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        OpCode  = alu_dec;
      end
      StAluWb: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 2'b10;
        OpCode     = AluSub;
        PCWrite    = branch_taken;
        instr_done = 1'b1;
      end
      StJal: PCWrite = 1'b1;
      StJalr: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      StLink: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      StLui: begin
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    // Reset must not let a half-finished instruction touch architectural state.
    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_retired <= '0;
    end else if (instr_done) begin
      instr_retired <= instr_retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle control vectors compared against an instruction-level sequence
// model; a narrow counter is used so retirement wrap-around is exercised.
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instruction;
  logic          ZERO;
  logic          PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, instr_done;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]    OpCode, ImmSrc;
  logic [CW-1:0] instr_retired;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [CW-1:0] ret_m   = '0;

  typedef struct packed {
    logic       pcw, irw, rw, mw, adr;
    logic [1:0] sa, sb, rs;
    logic [2:0] op, imm;
    logic       done;
  } ctl_t;

  multicycle_controller #(.COUNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .ZERO         (ZERO),
    .PCWrite      (PCWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .AdrSrc       (AdrSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ResultSrc    (ResultSrc),
    .OpCode       (OpCode),
    .ImmSrc       (ImmSrc),
    .instr_done   (instr_done),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    return {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            OpCode, ImmSrc, instr_done};
  endfunction

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 jalr, 7 lui, 8 illegal.
  function automatic int cls_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      7'b0110111: return 7;
      default:    return 8;
    endcase
  endfunction

  function automatic int latency(input logic [31:0] ins);
    int lat[9] = '{5, 4, 4, 4, 3, 4, 4, 3, 2};
    return lat[cls_of(ins)];
  endfunction

  function automatic logic [2:0] alu_of(input logic [31:0] ins, input bit rtype);
    case (ins[14:12])
      3'b000:  return (rtype && ins[30]) ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b010:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit taken(input logic [31:0] ins, input logic z);
    bit t;
    t = (ins[14:12] == 3'b000) && z;
`ifdef BNE_EN
    t = t || ((ins[14:12] == 3'b001) && !z);
`endif
    return t;
  endfunction

  // Expected controls in cycle k of an instruction (k=0 fetch, k=1 decode).
  function automatic ctl_t model(input logic [31:0] ins, input logic z, input int k);
    ctl_t c;
    int   cl;
    c  = '0;
    cl = cls_of(ins);
    case (cl)
      1: c.imm = 3'd1;
      4: c.imm = 3'd2;
      5: c.imm = 3'd3;
      7: c.imm = 3'd4;
      default: c.imm = 3'd0;
    endcase
    if (k == 0) begin
      c.irw = 1; c.sb = 2; c.rs = 2; c.pcw = 1;
    end else if (k == 1) begin
      c.sa = 1; c.sb = 1; c.done = (cl == 8);
    end else if (k == 2) begin
      case (cl)
        0, 1: begin c.sa = 2; c.sb = 1; end
        2: begin c.sa = 2; c.op = alu_of(ins, 1'b1); end
        3: begin c.sa = 2; c.sb = 1; c.op = alu_of(ins, 1'b0); end
        4: begin c.sa = 2; c.op = 3'd1; c.pcw = taken(ins, z); c.done = 1; end
        5: c.pcw = 1;
        6: begin c.sa = 2; c.sb = 1; c.rs = 2; c.pcw = 1; end
        7: begin c.rs = 3; c.rw = 1; c.done = 1; end
        default: ;
      endcase
    end else if (k == 3) begin
      case (cl)
        0: c.adr = 1;
        1: begin c.adr = 1; c.mw = 1; c.done = 1; end
        2, 3: begin c.rw = 1; c.done = 1; end
        5, 6: begin c.sa = 1; c.sb = 2; c.rs = 2; c.rw = 1; c.done = 1; end
        default: ;
      endcase
    end else if (k == 4 && cl == 0) begin
      c.rs = 1; c.rw = 1; c.done = 1;
    end
    return c;
  endfunction

  // Caller is #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z, input string name);
    ctl_t exp_c, got;
    instruction = ins;
    ZERO        = z;
    for (int k = 0; k < latency(ins); k++) begin
      @(negedge clk);
      exp_c = model(ins, z, k);
      got   = observed();
      n_tests++;
      if (got !== exp_c) begin
        n_fail++;
        $display("FAIL %s instr=%h zero=%0b cycle=%0d got=%h expected=%h",
                 name, ins, z, k, got, exp_c);
      end
      @(posedge clk);
      if (exp_c.done) ret_m = ret_m + 1'b1;
      #1;
    end
    n_tests++;
    if (instr_retired !== ret_m) begin
      n_fail++;
      $display("FAIL %s retired got=%0d expected=%0d", name, instr_retired, ret_m);
    end
  endtask

  task automatic test_reset();
    ctl_t exp_c, got;
    rst         = 1'b1;
    instruction = $urandom;
    ZERO        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_c = model(instruction, ZERO, 0);
    exp_c.pcw = 0; exp_c.irw = 0;
    got   = observed();
    n_tests++;
    if (got !== exp_c) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h expected=%h", got, exp_c);
    end
    n_tests++;
    if (instr_retired !== '0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d expected=0", instr_retired);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    ret_m = '0;
  endtask

  task automatic test_directed();
    run_instr(32'h002081B3, 1'b0, "add");
    run_instr(32'h402081B3, 1'b0, "sub");
    run_instr(32'h00802283, 1'b0, "lw");
    run_instr(32'h0050A423, 1'b0, "sw");
    run_instr(32'h00208463, 1'b1, "beq_taken");
    run_instr(32'h00208463, 1'b0, "beq_not_taken");
    run_instr(32'h010000EF, 1'b0, "jal");
    run_instr(32'h000080E7, 1'b0, "jalr");
    run_instr(32'h123450B7, 1'b0, "lui");
    run_instr(32'hFFFFFFFF, 1'b1, "illegal");
    run_instr(32'h00209463, 1'b0, "bne_zero0");
    run_instr(32'h00209463, 1'b1, "bne_zero1");
    run_instr(32'h4000E093, 1'b0, "ori_bit30");
    run_instr(32'h40000093, 1'b0, "addi_bit30");
  endtask

  task automatic test_reset_abort();
    ctl_t exp_c, got;
    logic [31:0] ins = 32'h00802283;
    instruction = ins;
    ZERO        = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    exp_c = model(ins, 1'b0, 3);
    got   = observed();
    n_tests++;
    if (got !== exp_c) begin
      n_fail++;
      $display("FAIL abort_memread got=%h expected=%h", got, exp_c);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    ret_m = '0;
    n_tests++;
    if (instr_retired !== '0) begin
      n_fail++;
      $display("FAIL abort_count got=%0d expected=0", instr_retired);
    end
    run_instr(32'h002081B3, 1'b0, "after_abort");
  endtask

  task automatic test_random(input int n);
    logic [6:0]  ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    logic [31:0] ins;
    int          c;
    for (int i = 0; i < n; i++) begin
      ins = $urandom;
      c   = $urandom_range(0, 8);
      if (c < 8) begin
        ins[6:0] = ops[c];
      end else if (cls_of(ins) != 8) begin
        ins[6:0] = 7'h7F;
      end
      if (c == 4) ins[14:12] = ($urandom_range(0, 2) == 0) ? 3'b001 : ins[14:12];
      run_instr(ins, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_random(300);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter COUNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 instruction  in  32  IR contents from the multicycle datapath; uses [6:0] op, [14:12] funct3, [30] funct7b5.
REQ-005 ZERO  in  1  ALU zero flag from the datapath.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  datapath write enables.
REQ-007 AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
REQ-008 ALUSrcA  out  2  select: 00 = PC, 01 = OldPC, 10 = rs1 register A.
REQ-009 ALUSrcB  out  2  select: 00 = register B, 01 = immediate, 10 = constant 4.
REQ-010 ResultSrc  out  2  select: 00 = ALUOut, 01 = memory data, 10 = ALU result, 11 = immediate.
REQ-011 OpCode  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
REQ-012 ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 instr_done  out  1  one-cycle pulse in the final state of every instruction.
REQ-014 instr_retired  out  COUNT_W  count of completed instructions.

Function
REQ-015 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI.
REQ-016 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1; next DECODE.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ADD, which latches the branch/JAL target into ALUOut. Next state by op:
- 0000011/0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- any other op -> FETCH with instr_done=1 and no writes.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ADD; next MEMREAD for op 0000011, else MEMWRITE.
REQ-019 MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
REQ-020 EXECR/EXECI: ALUSrcA=10, ALUSrcB=00/01 respectively -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-021 ALU decode in EXECR/EXECI by funct3:
- 000 -> SUB if EXECR and funct7b5=1, else ADD
- 111 -> AND
- 110 -> OR
- 010 -> SLT
- other -> ADD
- All other states use the OpCode stated for that state.
REQ-022 BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, PCWrite=(funct3==000)&ZERO -> FETCH.
REQ-023 JAL: ResultSrc=00, PCWrite=1 -> LINK.
- JALR: ALUSrcA=10, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1 -> LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, RegWrite=1 -> FETCH.
REQ-024 LUI: ResultSrc=11, RegWrite=1 -> FETCH.
REQ-025 ImmSrc is a function of op only, valid in every state:
- 0100011 -> S
- 1100011 -> B
- 1101111 -> J
- 0110111 -> U
- otherwise I
REQ-026 Unlisted control outputs are 0 in every state.
REQ-027 Latency in cycles, FETCH to FETCH inclusive:
- lw 5
- sw 4
- R/I 4
- JAL/JALR 4
- branch 3
- LUI 3
- illegal op 2
REQ-028 instr_done=1 in MEMWB, MEMWRITE, ALUWB, BRANCH, LINK, LUI, and in DECODE for illegal op.
REQ-029 instr_retired increments by 1 on each clock edge with instr_done=1; wraps from all-ones to 0.

Reset
REQ-030 On a rising clk with rst=1: state becomes FETCH and instr_retired becomes 0, regardless of current state (mid-instruction aborts with no further writes).
REQ-031 While rst=1, PCWrite, IRWrite, RegWrite, MemWrite and instr_done are forced 0 combinationally; after reset, the first cycle is FETCH.

Configuration
REQ-032 Macro BNE_EN:
- Defined: BRANCH with funct3=001 asserts PCWrite=~ZERO.
- Undefined: BRANCH with funct3 other than 000 never asserts PCWrite, and it still retires (instr_done=1).

Verification
REQ-033 Reset, then add x3,x1,x2 (0x002081B3) -> states FETCH,DECODE,EXECR,ALUWB; OpCode=000; RegWrite=1 in cycle 4 only; instr_retired=1.
REQ-034 sub (0x402081B3) -> OpCode=001 in EXECR.
- lw x5,8(x0) (0x00802283) -> 5 cycles, MemWrite=0, RegWrite=1 in MEMWB with ResultSrc=01.
REQ-035 beq x1,x2,+8 (0x00208463):
- ZERO=1 -> PCWrite=1 in BRANCH.
- ZERO=0 -> PCWrite=0.
- Both cases take 3 cycles.
REQ-036 jal x1,+16 (0x010000EF) -> ImmSrc=011 throughout; PCWrite in JAL; RegWrite with ALUSrcA=01, ALUSrcB=10 in LINK; 4 cycles.
REQ-037 rst asserted in MEMREAD -> next state FETCH, no RegWrite pulse, instr_retired=0.
- instruction=0xFFFFFFFF -> returns to FETCH after 2 cycles with instr_done=1 and no writes.
REQ-038 With BNE_EN, bne (0x00209463) and ZERO=0 -> PCWrite=1; without BNE_EN -> PCWrite=0.
